// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath definitions: unstuffer FSM states, stream byte constants and widths.
package jpeg_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WIN_W  = 16;
    localparam int unsigned LEN_W  = 5;

    localparam logic [BYTE_W-1:0] JPEG_FF    = 8'hFF;
    localparam logic [BYTE_W-1:0] JPEG_STUFF = 8'h00;
    localparam logic [BYTE_W-1:0] RST0       = 8'hD0;
    localparam logic [BYTE_W-1:0] RST1       = 8'hD1;
    localparam logic [BYTE_W-1:0] RST2       = 8'hD2;
    localparam logic [BYTE_W-1:0] RST3       = 8'hD3;
    localparam logic [BYTE_W-1:0] RST4       = 8'hD4;
    localparam logic [BYTE_W-1:0] RST5       = 8'hD5;
    localparam logic [BYTE_W-1:0] RST6       = 8'hD6;
    localparam logic [BYTE_W-1:0] RST7       = 8'hD7;
    localparam logic [BYTE_W-1:0] EOI        = 8'hD9;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_SAW_FF = 2'd1,
        ST_MARKER = 2'd2
    } unstuff_state_t;

    // True for restart-interval markers RST0..RST7.
    function automatic logic is_rst_marker(input logic [BYTE_W-1:0] code);
        return (code >= RST0) && (code <= RST7);
    endfunction

endpackage

// File: rtl/jpeg_bitbuf.sv
// Left-aligned shift/append bit buffer: consume from the top, append bytes at the fill count.
module jpeg_bitbuf
    import jpeg_pkg::*;
#(
    parameter int unsigned BUF_W = 32
) (
    input  logic                   clk_i,
    input  logic                   clear_i,
    input  logic                   append_i,
    input  logic [BYTE_W-1:0]      append_byte_i,
    input  logic                   shift_i,
    input  logic [LEN_W-1:0]       shift_len_i,
    output logic [WIN_W-1:0]       data_o,
    output logic [$clog2(BUF_W):0] cnt_o
);

    localparam int unsigned CNT_W = $clog2(BUF_W) + 1;

    logic [BUF_W-1:0] data_q, data_d, data_shift;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_shift;

    // Shift first, then append the new byte just below the surviving bits.
    always_comb begin
        data_shift = data_q;
        cnt_shift  = cnt_q;
        if (shift_i) begin
            data_shift = data_q << shift_len_i;
            cnt_shift  = cnt_q - CNT_W'(shift_len_i);
        end
        data_d = data_shift;
        cnt_d  = cnt_shift;
        if (append_i) begin
            data_d = data_shift | ({append_byte_i, {(BUF_W-BYTE_W){1'b0}}} >> cnt_shift);
            cnt_d  = cnt_shift + CNT_W'(BYTE_W);
        end
        if (clear_i) begin
            data_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        cnt_q  <= cnt_d;
    end

    assign data_o = data_q[BUF_W-1 -: WIN_W];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/jpeg_bit_unstuffer.sv
// JPEG entropy-segment reader: strips FF00 stuffing and FF fill, flags markers, serves a 16-bit window.
module jpeg_bit_unstuffer
    import jpeg_pkg::*;
#(
    parameter int unsigned BUF_W       = 32,
    parameter int unsigned MAX_CONSUME = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [BYTE_W-1:0]      in_byte_i,
    output logic [WIN_W-1:0]       bits_data_o,
    output logic [$clog2(BUF_W):0] bits_avail_o,
    input  logic                   consume_valid_i,
    input  logic [LEN_W-1:0]       consume_len_i,
    output logic                   marker_valid_o,
    output logic [BYTE_W-1:0]      marker_code_o,
    input  logic                   marker_ack_i,
    output logic                   err_o
);

    localparam int unsigned CNT_W = $clog2(BUF_W) + 1;

    unstuff_state_t    state_q;
    logic              marker_valid_q;
    logic [BYTE_W-1:0] marker_code_q;
    logic              err_q;

    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              consume_ok;
    logic              append;
    logic [BYTE_W-1:0] append_byte;
    logic              clear;

    // in_ready depends only on registered state, never on the consume request.
    assign in_ready_o = (state_q != ST_MARKER) && (cnt <= CNT_W'(BUF_W - BYTE_W));
    assign accept     = in_valid_i && in_ready_o;
    assign consume_ok = (consume_len_i != '0)
                     && (consume_len_i <= LEN_W'(MAX_CONSUME))
                     && (CNT_W'(consume_len_i) <= cnt);

    // Buffer control: a stuffed pair contributes a literal FF data byte.
    always_comb begin
        append      = 1'b0;
        append_byte = in_byte_i;
        if (accept) begin
            if (state_q == ST_NORMAL && in_byte_i != JPEG_FF) begin
                append = 1'b1;
            end else if (state_q == ST_SAW_FF && in_byte_i == JPEG_STUFF) begin
                append      = 1'b1;
                append_byte = JPEG_FF;
            end
        end
        clear = rst_i || (state_q == ST_MARKER && marker_ack_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_NORMAL;
            marker_valid_q <= 1'b0;
            marker_code_q  <= '0;
            err_q          <= 1'b0;
        end else begin
            if (consume_valid_i && !consume_ok) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                ST_NORMAL: begin
                    if (accept && in_byte_i == JPEG_FF) begin
                        state_q <= ST_SAW_FF;
                    end
                end
                ST_SAW_FF: begin
                    if (accept) begin
                        if (in_byte_i == JPEG_STUFF) begin
                            state_q <= ST_NORMAL;
                        end else if (in_byte_i != JPEG_FF) begin
                            marker_code_q  <= in_byte_i;
                            marker_valid_q <= 1'b1;
                            state_q        <= ST_MARKER;
                        end
                    end
                end
                ST_MARKER: begin
                    if (marker_ack_i) begin
                        marker_valid_q <= 1'b0;
                        state_q        <= ST_NORMAL;
                    end
                end
                default: state_q <= ST_NORMAL;
            endcase
        end
    end

    jpeg_bitbuf #(
        .BUF_W (BUF_W)
    ) u_bitbuf (
        .clk_i         (clk_i),
        .clear_i       (clear),
        .append_i      (append),
        .append_byte_i (append_byte),
        .shift_i       (consume_valid_i && consume_ok),
        .shift_len_i   (consume_len_i),
        .data_o        (bits_data_o),
        .cnt_o         (cnt)
    );

    assign bits_avail_o   = cnt;
    assign marker_valid_o = marker_valid_q;
    assign marker_code_o  = marker_code_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_jpeg_bit_unstuffer.sv
// Directed bench for jpeg_bit_unstuffer with hand-computed expectations.
module tb_jpeg_bit_unstuffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = 8'h00;
    logic [15:0] bits_data;
    logic [5:0]  bits_avail;
    logic        consume_valid = 1'b0;
    logic [4:0]  consume_len = 5'd0;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        marker_ack = 1'b0;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jpeg_bit_unstuffer dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_byte_i       (in_byte),
        .bits_data_o     (bits_data),
        .bits_avail_o    (bits_avail),
        .consume_valid_i (consume_valid),
        .consume_len_i   (consume_len),
        .marker_valid_o  (marker_valid),
        .marker_code_o   (marker_code),
        .marker_ack_i    (marker_ack),
        .err_o           (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume(input logic [4:0] len);
        consume_valid = 1'b1;
        consume_len   = len;
        tick();
        consume_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".in_ready"},     32'(in_ready),     32'h1);
        chk({tag, ".bits_avail"},   32'(bits_avail),   32'h0);
        chk({tag, ".bits_data"},    32'(bits_data),    32'h0);
        chk({tag, ".marker_valid"}, 32'(marker_valid), 32'h0);
        chk({tag, ".marker_code"},  32'(marker_code),  32'h0);
        chk({tag, ".err"},          32'(err),          32'h0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk_reset("reset");

        // Plain bytes, then a 3-bit consume
        send(8'hA5);
        send(8'h3C);
        chk("ab.avail", 32'(bits_avail), 32'd16);
        chk("ab.data",  32'(bits_data),  32'hA53C);
        consume(5'd3);
        chk("c3.data",  32'(bits_data),  32'h29E0);
        chk("c3.avail", 32'(bits_avail), 32'd13);
        consume(5'd13);
        chk("drain1.avail", 32'(bits_avail), 32'd0);
        chk("drain1.data",  32'(bits_data),  32'h0);

        // Stuffed FF00 yields a literal FF
        send(8'hFF);
        send(8'h00);
        send(8'h12);
        chk("stuff.avail",  32'(bits_avail),   32'd16);
        chk("stuff.data",   32'(bits_data),    32'hFF12);
        chk("stuff.marker", 32'(marker_valid), 32'h0);
        consume(5'd16);
        chk("drain2.avail", 32'(bits_avail), 32'd0);

        // Fill byte before a marker; marker blocks input until acked
        send(8'h81);
        send(8'hFF);
        send(8'hFF);
        chk("fill.avail",  32'(bits_avail),   32'd8);
        chk("fill.marker", 32'(marker_valid), 32'h0);
        send(8'hD9);
        chk("eoi.valid", 32'(marker_valid), 32'h1);
        chk("eoi.code",  32'(marker_code),  32'hD9);
        chk("eoi.avail", 32'(bits_avail),   32'd8);
        chk("eoi.data",  32'(bits_data),    32'h8100);
        chk("eoi.ready", 32'(in_ready),     32'h0);
        marker_ack = 1'b1;
        tick();
        marker_ack = 1'b0;
        chk("ack.avail", 32'(bits_avail),   32'd0);
        chk("ack.ready", 32'(in_ready),     32'h1);
        chk("ack.valid", 32'(marker_valid), 32'h0);
        chk("ack.data",  32'(bits_data),    32'h0);

        // Fill to 32 bits, then consume while a byte is offered
        send(8'h11);
        send(8'h22);
        send(8'h33);
        chk("full24.ready", 32'(in_ready), 32'h1);
        send(8'h44);
        chk("full.avail", 32'(bits_avail), 32'd32);
        chk("full.ready", 32'(in_ready),   32'h0);
        chk("full.data",  32'(bits_data),  32'h1122);
        in_valid      = 1'b1;
        in_byte       = 8'h55;
        consume_valid = 1'b1;
        consume_len   = 5'd16;
        tick();
        consume_valid = 1'b0;
        in_valid      = 1'b0;
        chk("c16.avail", 32'(bits_avail), 32'd16);
        chk("c16.ready", 32'(in_ready),   32'h1);
        chk("c16.data",  32'(bits_data),  32'h3344);
        // Steady stream: consume 8 and feed 1 byte every cycle
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp_data;
            in_valid      = 1'b1;
            in_byte       = 8'(8'h60 + i);
            consume_valid = 1'b1;
            consume_len   = 5'd8;
            tick();
            exp_data = (i == 0) ? 16'h4460 : {8'(8'h60 + i - 1), 8'(8'h60 + i)};
            chk($sformatf("stream%0d.avail", i), 32'(bits_avail), 32'd16);
            chk($sformatf("stream%0d.data", i),  32'(bits_data),  32'(exp_data));
        end
        in_valid      = 1'b0;
        consume_valid = 1'b0;
        consume(5'd16);
        chk("drain3.avail", 32'(bits_avail), 32'd0);

        // Over-consume is rejected and latches err
        send(8'hF0);
        send(8'hA5);
        consume(5'd12);
        chk("four.avail", 32'(bits_avail), 32'd4);
        chk("four.data",  32'(bits_data),  32'h5000);
        chk("four.err",   32'(err),        32'h0);
        consume(5'd5);
        chk("over.err",   32'(err),        32'h1);
        chk("over.avail", 32'(bits_avail), 32'd4);
        chk("over.data",  32'(bits_data),  32'h5000);
        consume(5'd4);
        chk("legal.avail", 32'(bits_avail), 32'd0);
        chk("legal.err",   32'(err),        32'h1);

        // Reset while a marker is pending
        send(8'hFF);
        send(8'hD0);
        chk("rst0.valid", 32'(marker_valid), 32'h1);
        chk("rst0.code",  32'(marker_code),  32'hD0);
        rst = 1'b1;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        send(8'h12);
        chk("post.avail", 32'(bits_avail), 32'd8);
        chk("post.data",  32'(bits_data),  32'h1200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jpeg_bit_unstuffer.md
# jpeg_bit_unstuffer

Entropy-segment reader for the JPEG datapath: the decode-side counterpart of `jpeg_encoder`'s bit packer and byte stuffer. It accepts the byte stream that `jpeg_encoder` emits, removes `0xFF 0x00` stuffing and `0xFF` fill bytes, and detects markers. It exposes the result as a left-aligned bit window from which a downstream Huffman decoder consumes 1–16 bits per cycle. The block is also used in the loopback bench that checks encoder output.

## Interface
Parameters:
- `BUF_W`, default 32: bit-buffer width; fixed at 32, other values unsupported.
- `MAX_CONSUME`, default 16: largest legal `consume_len`.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_byte` valid.
- `in_ready` out 1: block accepts `in_byte` this cycle.
- `in_byte` in 8: next stream byte.
- `bits_data` out 16: next 16 unconsumed bits, MSB = oldest; bits past `bits_avail` read 0.
- `bits_avail` out 6: valid bits in buffer, 0–32.
- `consume_valid` in 1: drop `consume_len` bits this cycle.
- `consume_len` in 5: 1–16.
- `marker_valid` out 1: marker detected, held until acknowledged.
- `marker_code` out 8: second byte of the marker.
- `marker_ack` in 1: consumer has handled the marker.
- `err` out 1: sticky; set on illegal consume.

## Operation
- State: 32-bit shift register `buf`, left-aligned; 6-bit `cnt`; FSM {NORMAL, SAW_FF, MARKER}.
- `in_ready` = (state != MARKER) && (`cnt` <= 24). It is combinational from registers only, with no dependence on `consume_valid`.
- A byte is accepted when `in_valid && in_ready`.
- NORMAL:
  - Byte != `0xFF`: append at bit position `cnt`; `cnt` += 8.
  - Byte == `0xFF`: go to SAW_FF; append nothing.
- SAW_FF:
  - `0x00`: append `0xFF`; go to NORMAL.
  - `0xFF`: fill byte; drop it and stay in SAW_FF.
  - Any other byte: `marker_code` <= byte; `marker_valid` <= 1; go to MARKER.
- MARKER:
  - No input is accepted.
  - Bits already in `buf` remain consumable.
  - On `marker_ack`: `cnt` <= 0 (residual padding discarded); `marker_valid` <= 0; go to NORMAL.
- `marker_ack` outside MARKER is ignored.
- Consume: if `consume_valid` and 1 <= `consume_len` <= min(16, `cnt`), shift `buf` left by `consume_len` and set `cnt` -= `consume_len`. Otherwise the request is ignored and `err` <= 1.
- Simultaneous consume and append: shift first, then append at the new `cnt`. Result: `cnt` = `cnt` − len + 8.
- Simultaneous consume and `marker_ack`: `cnt` <= 0; `err` is not set if the consume was legal.
- Vacated low bits of `buf` are zero-filled.

## Timing
- Reset values:
  - `in_ready` = 1, `bits_avail` = 0, `bits_data` = 0.
  - `marker_valid` = 0, `marker_code` = 0, `err` = 0.
  - State = NORMAL.
- Latency: a byte accepted at edge k appears in `bits_data`/`bits_avail` after edge k.
- A marker byte accepted at edge k raises `marker_valid` after edge k. `in_ready` is 0 from the same point.
- A consume at edge k is reflected after edge k. Throughput is one byte in and up to 16 bits out per cycle.
- Full: `cnt` >= 25 deasserts `in_ready`. `cnt` never exceeds 32.
- `rst` mid-marker or mid-SAW_FF returns to reset values on the next edge. A pending `0xFF` is lost.

## Structure
- Shared package `jpeg_pkg`: FSM enum `unstuff_state_t`, `JPEG_FF = 8'hFF`, `JPEG_STUFF = 8'h00`, `RST0..RST7` / `EOI = 8'hD9` constants.
- One sub-module, `jpeg_bitbuf`: the 32-bit shift/append buffer with count. It takes `append`, `append_byte`, `shift`, `shift_len`, `clear` and outputs `data`/`cnt`. The FSM and handshake stay in the top.

## Test plan
- Bytes `A5`, `3C`, no consume → `bits_avail` = 16, `bits_data` = `0xA53C`. Then consume 3 → `bits_data` = `0x29E0`, `bits_avail` = 13.
- Bytes `FF 00 12` → `bits_avail` = 16, `bits_data` = `0xFF12`, `marker_valid` stays 0.
- Bytes `81 FF FF D9` → after `D9`: `marker_valid` = 1, `marker_code` = `0xD9`, `bits_avail` = 8, `in_ready` = 0. Then `marker_ack` → `bits_avail` = 0, `in_ready` = 1.
- Bytes `11 22 33 44` with no consume → `bits_avail` = 32, `in_ready` = 0. Then consume 16 with `in_valid` and byte `55` → `in_ready` deasserts at 32 and reasserts at 16 with `bits_data` = `0x3344`. Continuous consume 8 plus feed runs at 1 byte/cycle with `bits_avail` constant.
- With `bits_avail` = 4, consume 5 → `err` = 1 and `bits_avail` still 4. A following legal consume 4 → `bits_avail` = 0, `err` stays 1.
- Bytes `FF D0` then `rst` before `marker_ack` → next cycle all outputs at reset values. Then `12` → `bits_avail` = 8.
